canvas_pixel_streamer: RTL and testbench

- Upstream feeder of the digit-recognition CNN stage.
- Turns PS/2 mouse reports (movement plus buttons) into a 28x28 binary drawing canvas.
- On request, streams the canvas in raster order as 8-bit pixels on the CNN pixel input interface (pixel + valid, no backpressure).
- Also exports the canvas bitmap and cursor position for the VGA overlay.

---
 rtl/canvas_pixel_streamer.sv | 149 ++++++++++++++
 tb/tb_canvas_pixel_streamer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/canvas_pixel_streamer.sv
// Mouse-driven 28x28 binary drawing canvas that streams its pixels in raster order
// to the CNN input interface and exports the bitmap and cursor for the VGA overlay.
module canvas_pixel_streamer #(
    parameter int GRID   = 28,
    parameter int SHIFT  = 2,
    parameter int GAP    = 0,
    parameter int BRUSH2 = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_button_left,
    input  logic                 i_button_right,
    input  logic [8:0]           i_movement_x,
    input  logic [8:0]           i_movement_y,
    input  logic                 i_valid,
    input  logic                 i_start,
    output logic [7:0]           o_pixel,
    output logic                 o_pixel_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [GRID*GRID-1:0] o_canvas,
    output logic [4:0]           o_cursor_col,
    output logic [4:0]           o_cursor_row
);
    localparam int NPIX  = GRID * GRID;
    localparam int BIT_W = $clog2(NPIX);
    localparam int IDX_W = $clog2(NPIX + 1);
    localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic signed [11:0] FINE_MAX  = 12'((GRID << SHIFT) - 1);
    localparam logic signed [11:0] FINE_HOME = 12'((GRID / 2) << SHIFT);

    typedef enum logic {S_DRAW, S_STREAM} state_t;

    state_t             state_q, state_d;
    logic signed [11:0] fine_x_q, fine_x_d, fine_y_q, fine_y_d;
    logic [NPIX-1:0]    canvas_q, canvas_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [7:0]         pixel_q, pixel_d;
    logic               pixel_valid_q, pixel_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic signed [11:0] dx_ext, dy_ext;
    int                 cur_col, cur_row;

    function automatic logic signed [11:0] sat_fine(input logic signed [11:0] v);
        if (v < 12'sd0) return 12'sd0;
        if (v > FINE_MAX) return FINE_MAX;
        return v;
    endfunction

    assign dx_ext = {{3{i_movement_x[8]}}, i_movement_x};
    assign dy_ext = {{3{i_movement_y[8]}}, i_movement_y};

    always_comb begin
        state_d       = state_q;
        canvas_d      = canvas_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        pixel_d       = pixel_q;
        pixel_valid_d = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        fine_x_d      = fine_x_q;
        fine_y_d      = fine_y_q;
        cur_col       = int'(fine_x_q >>> SHIFT);
        cur_row       = int'(fine_y_q >>> SHIFT);

        // Mouse y grows upward while canvas rows grow downward.
        if (i_valid) begin
            fine_x_d = sat_fine(fine_x_q + dx_ext);
            fine_y_d = sat_fine(fine_y_q - dy_ext);
        end

        case (state_q)
            S_DRAW: begin
                if (i_start) begin
                    state_d       = S_STREAM;
                    busy_d        = 1'b1;
                    pixel_valid_d = 1'b1;
                    pixel_d       = canvas_q[0] ? 8'd255 : 8'd0;
                    idx_d         = IDX_W'(1);
                    gap_d         = GAP_W'(GAP);
                end else if (i_button_right) begin
                    canvas_d = '0;
                end else if (i_button_left) begin
                    for (int r = 0; r < GRID; r++) begin
                        for (int c = 0; c < GRID; c++) begin
                            if (r >= cur_row && r <= cur_row + BRUSH2 &&
                                c >= cur_col && c <= cur_col + BRUSH2) begin
                                canvas_d[BIT_W'(r * GRID + c)] = 1'b1;
                            end
                        end
                    end
                end
            end
            S_STREAM: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (idx_q == IDX_W'(NPIX)) begin
                    state_d = S_DRAW;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    idx_d   = '0;
                end else begin
                    pixel_valid_d = 1'b1;
                    pixel_d       = canvas_q[idx_q[BIT_W-1:0]] ? 8'd255 : 8'd0;
                    idx_d         = idx_q + IDX_W'(1);
                    gap_d         = GAP_W'(GAP);
                end
            end
            default: state_d = S_DRAW;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= S_DRAW;
            canvas_q      <= '0;
            fine_x_q      <= FINE_HOME;
            fine_y_q      <= FINE_HOME;
            idx_q         <= '0;
            gap_q         <= '0;
            pixel_q       <= 8'd0;
            pixel_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            canvas_q      <= canvas_d;
            fine_x_q      <= fine_x_d;
            fine_y_q      <= fine_y_d;
            idx_q         <= idx_d;
            gap_q         <= gap_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign o_pixel       = pixel_q;
    assign o_pixel_valid = pixel_valid_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_canvas      = canvas_q;
    assign o_cursor_col  = fine_x_q[SHIFT+4:SHIFT];
    assign o_cursor_row  = fine_y_q[SHIFT+4:SHIFT];
endmodule

// File: tb/tb_canvas_pixel_streamer.sv
// Scoreboard bench: two instances (GAP=0 and GAP=2) share the stimulus; a canvas/cursor
// model predicts state, and a negedge monitor checks every streamed pixel and done pulse.
module tb_canvas_pixel_streamer;
    localparam int GRID  = 28;
    localparam int SHIFT = 2;
    localparam int NPIX  = GRID * GRID;
    localparam int BW    = $clog2(NPIX);
    localparam int FMAX  = (GRID << SHIFT) - 1;
    localparam int FHOME = (GRID / 2) << SHIFT;

    typedef struct {
        int         cyc;
        logic [7:0] pix;
    } exp_t;

    logic clk, rst_n, bl, br, vin, st_in;
    logic [8:0] mx, my;
    logic [7:0] pix0, pix2;
    logic pv0, pv2, busy0, busy2, done0, done2;
    logic [NPIX-1:0] canvas0, canvas2;
    logic [4:0] col0, row0, col2, row2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fx, fy;
    logic [NPIX-1:0] cm;
    exp_t pq[2][$];
    int dq[2][$];
    int st[2];
    logic [7:0] last_pix[2];

    canvas_pixel_streamer #(.GRID(GRID), .SHIFT(SHIFT), .GAP(0), .BRUSH2(1)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_button_left(bl), .i_button_right(br),
        .i_movement_x(mx), .i_movement_y(my), .i_valid(vin), .i_start(st_in),
        .o_pixel(pix0), .o_pixel_valid(pv0), .o_busy(busy0), .o_done(done0),
        .o_canvas(canvas0), .o_cursor_col(col0), .o_cursor_row(row0));

    canvas_pixel_streamer #(.GRID(GRID), .SHIFT(SHIFT), .GAP(2), .BRUSH2(1)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_button_left(bl), .i_button_right(br),
        .i_movement_x(mx), .i_movement_y(my), .i_valid(vin), .i_start(st_in),
        .o_pixel(pix2), .o_pixel_valid(pv2), .o_busy(busy2), .o_done(done2),
        .o_canvas(canvas2), .o_cursor_col(col2), .o_cursor_row(row2));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_i(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_c(input string nm, input logic [NPIX-1:0] act, input logic [NPIX-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bit busy_at(input int s, input int g, input int c);
        return (c >= s + 1) && (c <= s + NPIX * (g + 1));
    endfunction

    function automatic int clampf(input int v);
        if (v < 0) return 0;
        if (v > FMAX) return FMAX;
        return v;
    endfunction

    // Reference behaviour of one clock edge, given the inputs held during cycle n.
    task automatic model_apply(input int n, input bit v, input int dx, input int dy,
                               input bit l, input bit r, input bit s);
        int col, row, g;
        exp_t e;
        bit idle;
        idle = !busy_at(st[0], 0, n) && !busy_at(st[1], 2, n);
        col = fx >> SHIFT;
        row = fy >> SHIFT;
        if (idle) begin
            if (s) begin
                for (int i = 0; i < 2; i++) begin
                    g = (i == 0) ? 0 : 2;
                    st[i] = n;
                    for (int k = 0; k < NPIX; k++) begin
                        e.cyc = n + 1 + k * (g + 1);
                        e.pix = cm[BW'(k)] ? 8'd255 : 8'd0;
                        pq[i].push_back(e);
                    end
                    dq[i].push_back(n + 1 + NPIX * (g + 1));
                end
            end else if (r) begin
                cm = '0;
            end else if (l) begin
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (row + dr < GRID && col + dc < GRID)
                            cm[BW'((row + dr) * GRID + col + dc)] = 1'b1;
            end
        end
        if (v) begin
            fx = clampf(fx + dx);
            fy = clampf(fy - dy);
        end
    endtask

    task automatic cyc_drive(input bit v, input int dx, input int dy,
                             input bit l, input bit r, input bit s);
        int n;
        vin = v; mx = 9'(dx); my = 9'(dy); bl = l; br = r; st_in = s;
        n = cyc;
        @(posedge clk);
        model_apply(n, v, dx, dy, l, r, s);
        #1;
        check_i("cursor_col0", int'(col0), fx >> SHIFT);
        check_i("cursor_row0", int'(row0), fy >> SHIFT);
        check_i("cursor_col2", int'(col2), fx >> SHIFT);
        check_i("cursor_row2", int'(row2), fy >> SHIFT);
        check_c("canvas0", canvas0, cm);
        check_c("canvas2", canvas2, cm);
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_i("rst_valid0", int'(pv0), 0);
        check_i("rst_valid2", int'(pv2), 0);
        check_i("rst_busy0", int'(busy0), 0);
        check_i("rst_busy2", int'(busy2), 0);
        check_i("rst_done0", int'(done0), 0);
        check_i("rst_done2", int'(done2), 0);
        check_i("rst_pixel0", int'(pix0), 0);
        check_i("rst_pixel2", int'(pix2), 0);
        check_c("rst_canvas0", canvas0, '0);
        check_c("rst_canvas2", canvas2, '0);
        check_i("rst_col", int'(col0), 14);
        check_i("rst_row", int'(row2), 14);
        cm = '0; fx = FHOME; fy = FHOME;
        for (int i = 0; i < 2; i++) begin
            st[i] = -1000000;
            pq[i].delete();
            dq[i].delete();
        end
        vin = 0; bl = 0; br = 0; st_in = 0; mx = '0; my = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic int rnd_delta();
        if ($urandom_range(0, 15) == 0) return int'($urandom_range(0, 511)) - 256;
        return int'($urandom_range(0, 40)) - 20;
    endfunction

    task automatic rand_cycles(input int count);
        for (int i = 0; i < count; i++)
            cyc_drive(1'($urandom_range(0, 1)), rnd_delta(), rnd_delta(),
                      1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0, 1'b0);
    endtask

    // Start a stream, then keep moving the mouse; buttons and start are hammered early on.
    task automatic run_stream(input int count, input int junk_until);
        bit j;
        cyc_drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= count; i++) begin
            j = (i < junk_until);
            cyc_drive(1'($urandom_range(0, 1)), rnd_delta(), rnd_delta(),
                      j && $urandom_range(0, 1) == 1, j && $urandom_range(0, 3) == 0,
                      j && $urandom_range(0, 7) == 0);
        end
    endtask

    task automatic mon_one(input int i, input int g, input logic [7:0] pix, input logic pv,
                           input logic bsy, input logic dn);
        exp_t e;
        int dc;
        check_i($sformatf("busy_%0d", i), int'(bsy), int'(busy_at(st[i], g, cyc)));
        if (pv) begin
            check_i($sformatf("valid_expected_%0d", i), int'(pq[i].size() > 0), 1);
            if (pq[i].size() > 0) begin
                e = pq[i].pop_front();
                check_i($sformatf("pixel_cycle_%0d", i), cyc, e.cyc);
                check_i($sformatf("pixel_value_%0d", i), int'(pix), int'(e.pix));
            end
            last_pix[i] = pix;
        end else if (bsy) begin
            check_i($sformatf("gap_hold_%0d", i), int'(pix), int'(last_pix[i]));
        end
        if (dn) begin
            check_i($sformatf("done_expected_%0d", i), int'(dq[i].size() > 0), 1);
            if (dq[i].size() > 0) begin
                dc = dq[i].pop_front();
                check_i($sformatf("done_cycle_%0d", i), cyc, dc);
            end
            check_i($sformatf("done_valid_low_%0d", i), int'(pv), 0);
        end else if (dq[i].size() > 0 && dq[i][0] <= cyc) begin
            check_i($sformatf("done_missing_%0d", i), int'(dn), 1);
            void'(dq[i].pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon_one(0, 0, pix0, pv0, busy0, done0);
            mon_one(1, 2, pix2, pv2, busy2, done2);
        end else begin
            last_pix[0] = 8'd0;
            last_pix[1] = 8'd0;
        end
    end

    initial begin
        logic [NPIX-1:0] expv;
        rst_n = 1'b0; vin = 0; bl = 0; br = 0; st_in = 0; mx = '0; my = '0;
        cm = '0; fx = FHOME; fy = FHOME;
        st[0] = -1000000; st[1] = -1000000;
        last_pix[0] = 8'd0; last_pix[1] = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        cyc_drive(1'b1, 8, 8, 1'b0, 1'b0, 1'b0);
        check_i("move_col16", int'(col0), 16);
        check_i("move_row12", int'(row0), 12);
        cyc_drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        expv = '0; expv[352] = 1'b1; expv[353] = 1'b1; expv[380] = 1'b1; expv[381] = 1'b1;
        check_c("brush_2x2", canvas0, expv);
        cyc_drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        cyc_drive(1'b1, 100, -100, 1'b0, 1'b0, 1'b0);
        cyc_drive(1'b1, 255, -256, 1'b0, 1'b0, 1'b0);
        check_i("sat_col_max", int'(col0), 27);
        check_i("sat_row_max", int'(row0), 27);
        cyc_drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        expv = '0; expv[783] = 1'b1;
        check_c("brush_clip", canvas0, expv);

        do_reset();
        repeat (2) cyc_drive(1'b1, -256, 0, 1'b0, 1'b0, 1'b0);
        check_i("sat_col_min", int'(col0), 0);
        repeat (3) cyc_drive(1'b1, 0, -256, 1'b0, 1'b0, 1'b0);
        check_i("sat_row_down", int'(row0), 27);

        cyc_drive(1'b1, 0, 255, 1'b0, 1'b0, 1'b0);
        cyc_drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        cyc_drive(1'b1, 255, -256, 1'b0, 1'b0, 1'b0);
        cyc_drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
        expv = '0; expv[0] = 1'b1; expv[1] = 1'b1; expv[28] = 1'b1; expv[29] = 1'b1; expv[783] = 1'b1;
        check_c("picture", canvas0, expv);
        run_stream(2400, 700);
        cyc_drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
        check_c("clear_after_stream", canvas0, '0);

        rand_cycles(600);
        run_stream(2400, 700);
        rand_cycles(300);
        run_stream(300, 100);
        check_i("pix100_valid0", int'(pv0), 1);
        check_i("pix100_valid2", int'(pv2), 1);
        do_reset();
        rand_cycles(2500);

        check_i("queues_drained", pq[0].size() + pq[1].size() + dq[0].size() + dq[1].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
